sparc_ifu_thrfsm_array: RTL and testbench

Parametrised per-core thread-state block for the IFU. It holds `NTHR` independent thread FSMs using the established 5-bit state encoding, with per-thread vectorised control inputs. It adds three functions on top of the FSMs: a round-robin ready-thread picker for the switch logic, a run-conflict checker, and a per-thread-addressed debug/JTAG state write. It sits between the fcl/switch logic, which drives the control vectors, and the swl scheduler, which consumes `thr_state`, `pick_*` and `wait_timeout`.

---
 rtl/sparc_ifu_thrfsm_array.sv | 207 ++++++++++++++++++++
 tb/tb_sparc_ifu_thrfsm_array.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_thrfsm_array.sv
// Per-core IFU thread-state array: NTHR thread FSMs, round-robin ready picker,
// run-conflict flag and debug state write. Optional WAIT timeout: THRFSM_WAIT_TIMEOUT_EN.
module sparc_ifu_thrfsm_array #(
  parameter int NTHR    = 4,
  parameter int TIDW    = 2,
  parameter int TMO_W   = 10,
  parameter int TMO_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NTHR-1:0]   completion,
  input  logic [NTHR-1:0]   schedule,
  input  logic [NTHR-1:0]   spec_ld,
  input  logic [NTHR-1:0]   ldhit,
  input  logic [NTHR-1:0]   stall,
  input  logic [NTHR-1:0]   int_activate,
  input  logic [NTHR-1:0]   halt_thread,
  input  logic [NTHR-1:0]   start_thread,
  input  logic [NTHR-1:0]   nuke_thread,
  input  logic [NTHR-1:0]   thaw_thread,
  input  logic [NTHR-1:0]   rst_thread,
  input  logic [NTHR-1:0]   switch_out,
  input  logic [NTHR-1:0]   sw_cond,
  input  logic              dbg_wr_en,
  input  logic [TIDW-1:0]   dbg_wr_tid,
  input  logic [4:0]        dbg_wr_data,
  output logic [5*NTHR-1:0] thr_state,
  output logic [5*NTHR-1:0] thr_nstate,
  output logic              pick_vld,
  output logic [TIDW-1:0]   pick_tid,
  output logic              pick_spec,
  output logic              run_conflict,
  output logic [NTHR-1:0]   wait_timeout
);

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00000,
    ST_HALT     = 5'b00010,
    ST_RDY      = 5'b11001,
    ST_RUN      = 5'b00101,
    ST_WAIT     = 5'b00001,
    ST_SPEC_RDY = 5'b10011,
    ST_SPEC_RUN = 5'b00111
  } thr_state_e;

  // Element i of the packed arrays lands on bits [5i+4:5i] of the flat ports.
  logic [NTHR-1:0][4:0] state_q, state_d, nstate;
  logic [TIDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 run_conflict_q, run_conflict_d;

  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      nstate[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (rst_thread[i] || thaw_thread[i])         nstate[i] = ST_WAIT;
          else if (start_thread[i])                    nstate[i] = ST_RDY;
        end
        ST_HALT: begin
          if (nuke_thread[i])                          nstate[i] = ST_IDLE;
          else if (rst_thread[i] || thaw_thread[i])    nstate[i] = ST_WAIT;
          else if (int_activate[i] || start_thread[i]) nstate[i] = ST_RDY;
        end
        ST_RDY: begin
          if (stall[i])                                nstate[i] = ST_WAIT;
          else if (schedule[i])                        nstate[i] = ST_RUN;
        end
        ST_RUN: begin
          if (stall[i] || sw_cond[i])                  nstate[i] = ST_WAIT;
          else if (switch_out[i])                      nstate[i] = ST_RDY;
        end
        ST_WAIT: begin
          if (nuke_thread[i])                          nstate[i] = ST_IDLE;
          else if (halt_thread[i])                     nstate[i] = ST_HALT;
          else if (stall[i])                           nstate[i] = ST_WAIT;
          else if (spec_ld[i])                         nstate[i] = ST_SPEC_RDY;
          else if (completion[i])                      nstate[i] = ST_RDY;
        end
        ST_SPEC_RDY: begin
          if (stall[i])                                nstate[i] = ST_WAIT;
          else if (schedule[i] && !ldhit[i])           nstate[i] = ST_SPEC_RUN;
          else if (schedule[i] && ldhit[i])            nstate[i] = ST_RUN;
          else if (ldhit[i])                           nstate[i] = ST_RDY;
        end
        ST_SPEC_RUN: begin
          if (stall[i] || sw_cond[i])                  nstate[i] = ST_WAIT;
          else if (ldhit[i] && switch_out[i])          nstate[i] = ST_RDY;
          else if (ldhit[i])                           nstate[i] = ST_RUN;
          else if (switch_out[i])                      nstate[i] = ST_SPEC_RDY;
        end
        default: begin
          if (rst_thread[i])                           nstate[i] = ST_WAIT;
          else if (nuke_thread[i])                     nstate[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Debug write overrides only the addressed thread; out-of-range tids match nothing.
  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      state_d[i] = nstate[i];
      if (dbg_wr_en && (dbg_wr_tid == TIDW'(i))) state_d[i] = dbg_wr_data;
    end
  end

  logic sched_found;
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    sched_found = 1'b0;
    for (int i = 0; i < NTHR; i++) begin
      if (!sched_found && schedule[i]) begin
        sched_found = 1'b1;
        rr_ptr_d    = (i == NTHR - 1) ? '0 : TIDW'(i + 1);
      end
    end
  end

  logic [NTHR-1:0] rdy_mask, spec_mask, cand_mask;
  logic            pick_found;
  int              pick_idx;
  always_comb begin
    pick_found = 1'b0;
    pick_tid   = '0;
    pick_idx   = 0;
    for (int i = 0; i < NTHR; i++) begin
      rdy_mask[i]  = (state_q[i] == ST_RDY);
      spec_mask[i] = (state_q[i] == ST_SPEC_RDY);
    end
    cand_mask = (|rdy_mask) ? rdy_mask : spec_mask;
    for (int j = 0; j < NTHR; j++) begin
      pick_idx = (int'(rr_ptr_q) + j) % NTHR;
      if (!pick_found && cand_mask[pick_idx]) begin
        pick_found = 1'b1;
        pick_tid   = TIDW'(pick_idx);
      end
    end
    pick_vld  = pick_found;
    pick_spec = pick_found && !(|rdy_mask);
  end

  logic [3:0] run_cnt;
  always_comb begin
    run_cnt = '0;
    for (int i = 0; i < NTHR; i++) begin
      if (state_q[i] == ST_RUN || state_q[i] == ST_SPEC_RUN) run_cnt = run_cnt + 4'd1;
    end
    run_conflict_d = run_conflict_q || (run_cnt >= 4'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= {NTHR{ST_IDLE}};
      rr_ptr_q       <= '0;
      run_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      run_conflict_q <= run_conflict_d;
    end
  end

  assign thr_state    = state_q;
  assign thr_nstate   = nstate;
  assign run_conflict = run_conflict_q;

`ifdef THRFSM_WAIT_TIMEOUT_EN
  logic [NTHR-1:0][TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [NTHR-1:0]            tmo_flag_q, tmo_flag_d;

  // Flag drops together with the state change out of WAIT.
  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      if (state_q[i] != ST_WAIT)                  tmo_cnt_d[i] = '0;
      else if (tmo_cnt_q[i] == TMO_W'(TMO_CYC))   tmo_cnt_d[i] = tmo_cnt_q[i];
      else                                        tmo_cnt_d[i] = tmo_cnt_q[i] + 1'b1;
      tmo_flag_d[i] = (state_q[i] == ST_WAIT) && (state_d[i] == ST_WAIT) &&
                      (tmo_flag_q[i] || (tmo_cnt_q[i] == TMO_W'(TMO_CYC)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= '0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign wait_timeout = tmo_flag_q;
`else
  assign wait_timeout = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    for (int i = 0; i < NTHR; i++) begin
      if (!reset && !(state_q[i] inside {ST_IDLE, ST_HALT, ST_RDY, ST_RUN, ST_WAIT,
                                         ST_SPEC_RDY, ST_SPEC_RUN}))
        $warning("thread %0d holds unknown state encoding %b", i, state_q[i]);
    end
  end
`endif

endmodule

// File: tb/tb_sparc_ifu_thrfsm_array.sv
// Directed bench for sparc_ifu_thrfsm_array: 4-thread main instance plus a
// 5-thread instance for out-of-range debug tids.
module tb_sparc_ifu_thrfsm_array;
  localparam logic [4:0] S_IDLE = 5'b00000, S_HALT = 5'b00010, S_RDY = 5'b11001,
                         S_RUN = 5'b00101, S_WAIT = 5'b00001, S_SPEC_RDY = 5'b10011,
                         S_SPEC_RUN = 5'b00111;

  // clock / reset
  logic clk, reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  completion, schedule, spec_ld, ldhit, stall, int_activate, halt_thread,
               start_thread, nuke_thread, thaw_thread, rst_thread, switch_out, sw_cond;
  logic        dbg_wr_en;
  logic [1:0]  dbg_wr_tid;
  logic [4:0]  dbg_wr_data;
  logic [19:0] thr_state, thr_nstate;
  logic        pick_vld, pick_spec, run_conflict;
  logic [1:0]  pick_tid;
  logic [3:0]  wait_timeout;

  logic        dbg5_en;
  logic [2:0]  dbg5_tid;
  logic [4:0]  dbg5_data;
  logic [4:0]  zero5;
  logic [24:0] thr_state5, thr_nstate5;
  logic        pick_vld5, pick_spec5, run_conflict5;
  logic [2:0]  pick_tid5;
  logic [4:0]  wait_timeout5;

  sparc_ifu_thrfsm_array #(.NTHR(4), .TIDW(2), .TMO_W(10), .TMO_CYC(4)) u_dut (
    .clk(clk), .reset(reset), .completion(completion), .schedule(schedule),
    .spec_ld(spec_ld), .ldhit(ldhit), .stall(stall), .int_activate(int_activate),
    .halt_thread(halt_thread), .start_thread(start_thread), .nuke_thread(nuke_thread),
    .thaw_thread(thaw_thread), .rst_thread(rst_thread), .switch_out(switch_out),
    .sw_cond(sw_cond), .dbg_wr_en(dbg_wr_en), .dbg_wr_tid(dbg_wr_tid),
    .dbg_wr_data(dbg_wr_data), .thr_state(thr_state), .thr_nstate(thr_nstate),
    .pick_vld(pick_vld), .pick_tid(pick_tid), .pick_spec(pick_spec),
    .run_conflict(run_conflict), .wait_timeout(wait_timeout)
  );

  sparc_ifu_thrfsm_array #(.NTHR(5), .TIDW(3), .TMO_W(10), .TMO_CYC(4)) u_dut5 (
    .clk(clk), .reset(reset), .completion(zero5), .schedule(zero5),
    .spec_ld(zero5), .ldhit(zero5), .stall(zero5), .int_activate(zero5),
    .halt_thread(zero5), .start_thread(zero5), .nuke_thread(zero5),
    .thaw_thread(zero5), .rst_thread(zero5), .switch_out(zero5),
    .sw_cond(zero5), .dbg_wr_en(dbg5_en), .dbg_wr_tid(dbg5_tid),
    .dbg_wr_data(dbg5_data), .thr_state(thr_state5), .thr_nstate(thr_nstate5),
    .pick_vld(pick_vld5), .pick_tid(pick_tid5), .pick_spec(pick_spec5),
    .run_conflict(run_conflict5), .wait_timeout(wait_timeout5)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    completion = '0; schedule = '0; spec_ld = '0; ldhit = '0; stall = '0;
    int_activate = '0; halt_thread = '0; start_thread = '0; nuke_thread = '0;
    thaw_thread = '0; rst_thread = '0; switch_out = '0; sw_cond = '0;
    dbg_wr_en = 1'b0; dbg_wr_tid = '0; dbg_wr_data = '0;
    dbg5_en = 1'b0; dbg5_tid = '0; dbg5_data = '0; zero5 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_clear();
    step();
    clear_inputs();
  endtask

  function automatic logic [4:0] st(input int i);
    return thr_state[5*i +: 5];
  endfunction

  function automatic logic [4:0] nst(input int i);
    return thr_nstate[5*i +: 5];
  endfunction

  function automatic logic [4:0] st5(input int i);
    return thr_state5[5*i +: 5];
  endfunction

  logic tmo_exp;

  initial begin
`ifdef THRFSM_WAIT_TIMEOUT_EN
    tmo_exp = 1'b1;
`else
    tmo_exp = 1'b0;
`endif
    clear_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    check("rst_state", 32'(thr_state), 32'h0);
    check("rst_nstate", 32'(thr_nstate), 32'h0);
    check("rst_pick_vld", 32'(pick_vld), 32'd0);
    check("rst_pick_tid", 32'(pick_tid), 32'd0);
    check("rst_pick_spec", 32'(pick_spec), 32'd0);
    check("rst_conflict", 32'(run_conflict), 32'd0);
    check("rst_tmo", 32'(wait_timeout), 32'd0);

    // start thread 2
    start_thread = 4'b0100;
    #1;
    check("start_nstate2", 32'(nst(2)), 32'(S_RDY));
    check("start_nstate0", 32'(nst(0)), 32'(S_IDLE));
    step_clear();
    check("start_state2", 32'(st(2)), 32'(S_RDY));
    check("start_pick_vld", 32'(pick_vld), 32'd1);
    check("start_pick_tid", 32'(pick_tid), 32'd2);
    check("start_pick_spec", 32'(pick_spec), 32'd0);

    // out-of-range debug tid on the 5-thread instance, then a legal one
    dbg5_en = 1'b1; dbg5_tid = 3'd5; dbg5_data = S_RDY;
    step_clear();
    check("dbg5_tid5_ignored", 32'(thr_state5), 32'h0);
    check("dbg5_tid5_pick_vld", 32'(pick_vld5), 32'd0);
    dbg5_en = 1'b1; dbg5_tid = 3'd4; dbg5_data = S_RDY;
    step_clear();
    check("dbg5_tid4_state", 32'(st5(4)), 32'(S_RDY));
    check("dbg5_tid4_pick", 32'(pick_tid5), 32'd4);

    // speculative path on thread 0
    thaw_thread = 4'b0001;
    step_clear();
    check("spec_wait", 32'(st(0)), 32'(S_WAIT));
    spec_ld = 4'b0001;
    step_clear();
    check("spec_rdy", 32'(st(0)), 32'(S_SPEC_RDY));
    check("spec_rdy_pick_tid", 32'(pick_tid), 32'd2);
    check("spec_rdy_pick_spec", 32'(pick_spec), 32'd0);
    schedule = 4'b0001;
    step_clear();
    check("spec_run", 32'(st(0)), 32'(S_SPEC_RUN));
    ldhit = 4'b0001;
    step_clear();
    check("spec_ldhit_run", 32'(st(0)), 32'(S_RUN));
    check("spec_conflict", 32'(run_conflict), 32'd0);

    // park threads 0 and 2 in WAIT
    stall = 4'b0101;
    step_clear();
    check("park_state0", 32'(st(0)), 32'(S_WAIT));
    check("park_state2", 32'(st(2)), 32'(S_WAIT));
    check("park_pick_vld", 32'(pick_vld), 32'd0);

    // schedule[1] while thread 1 is IDLE moves rr_ptr to 2; threads 1,3 start
    schedule = 4'b0010; start_thread = 4'b1010;
    step_clear();
    check("pick_state1", 32'(st(1)), 32'(S_RDY));
    check("pick_state3", 32'(st(3)), 32'(S_RDY));
    check("pick_rr2_tid", 32'(pick_tid), 32'd3);
    check("pick_rr2_vld", 32'(pick_vld), 32'd1);
    schedule = 4'b1000;
    step_clear();
    check("pick_state3_run", 32'(st(3)), 32'(S_RUN));
    check("pick_rr0_tid", 32'(pick_tid), 32'd1);

    // debug write of thread 1 over its FSM; thread 0 advances the same cycle
    dbg_wr_en = 1'b1; dbg_wr_tid = 2'd1; dbg_wr_data = S_HALT;
    start_thread = 4'b0010; completion = 4'b0001;
    #1;
    check("dbg_nstate1", 32'(nst(1)), 32'(S_RDY));
    check("dbg_nstate0", 32'(nst(0)), 32'(S_RDY));
    step_clear();
    check("dbg_state1", 32'(st(1)), 32'(S_HALT));
    check("dbg_state0", 32'(st(0)), 32'(S_RDY));
    check("dbg_pick_tid", 32'(pick_tid), 32'd0);

    // run conflict: threads 0 and 2 forced to RUN, thread 3 switched out
    dbg_wr_en = 1'b1; dbg_wr_tid = 2'd0; dbg_wr_data = S_RUN; switch_out = 4'b1000;
    step_clear();
    check("cfl_state0", 32'(st(0)), 32'(S_RUN));
    check("cfl_state3", 32'(st(3)), 32'(S_RDY));
    check("cfl_none_yet", 32'(run_conflict), 32'd0);
    dbg_wr_en = 1'b1; dbg_wr_tid = 2'd2; dbg_wr_data = S_RUN;
    step_clear();
    check("cfl_state2", 32'(st(2)), 32'(S_RUN));
    check("cfl_latency", 32'(run_conflict), 32'd0);
    step();
    check("cfl_set", 32'(run_conflict), 32'd1);
    stall = 4'b0101; nuke_thread = 4'b0010;
    step_clear();
    check("cfl_halt_nuke", 32'(st(1)), 32'(S_IDLE));
    check("cfl_left_run", 32'(st(0)), 32'(S_WAIT));
    step();
    check("cfl_sticky", 32'(run_conflict), 32'd1);
    reset = 1'b1;
    dbg_wr_en = 1'b1; dbg_wr_tid = 2'd3; dbg_wr_data = S_RUN;
    step_clear();
    reset = 1'b0;
    check("cfl_reset", 32'(run_conflict), 32'd0);
    check("cfl_reset_state", 32'(thr_state), 32'h0);

    // WAIT timeout on thread 0
    thaw_thread = 4'b0001;
    step_clear();
    check("tmo_wait", 32'(st(0)), 32'(S_WAIT));
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("tmo_cyc%0d", k), 32'(wait_timeout[0]), (k == 5) ? 32'(tmo_exp) : 32'd0);
    end
    completion = 4'b0001;
    step_clear();
    check("tmo_done_state", 32'(st(0)), 32'(S_RDY));
    check("tmo_done_clear", 32'(wait_timeout[0]), 32'd0);
    stall = 4'b0001;
    step_clear();
    repeat (6) step();
    check("tmo_second", 32'(wait_timeout), {31'd0, tmo_exp});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("tmo_reset_flag", 32'(wait_timeout), 32'd0);
    check("tmo_reset_state", 32'(st(0)), 32'(S_IDLE));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
